// File: rtl/core_pkg.sv
// Shared RV64 core definitions: opcode/funct7 encodings and the hazard FSM state type.
package core_pkg;

    localparam logic [6:0] OP_LOAD       = 7'b0000011;
    localparam logic [6:0] OP_OP         = 7'b0110011;
    localparam logic [6:0] OP_OP32       = 7'b0111011;
    localparam logic [6:0] OP_BRANCH     = 7'b1100011;
    localparam logic [6:0] OP_JAL        = 7'b1101111;
    localparam logic [6:0] OP_JALR       = 7'b1100111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MD_WAIT
    } hz_state_t;

    function automatic logic is_md_op(input logic [6:0] opcode, input logic [6:0] funct7);
        return ((opcode == OP_OP) || (opcode == OP_OP32)) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute/MD-unit signals seen by the hazard controller and the controls it returns.
interface hazard_ctrl_if;

    logic       id_valid;
    logic       id_rs1_re;
    logic       id_rs2_re;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic [4:0] id_rd_addr;
    logic       id_rd_we;
    logic [6:0] id_opcode;
    logic [6:0] id_funct7;
    logic       ex_valid;
    logic       ex_is_load;
    logic       ex_rd_we;
    logic [4:0] ex_rd_addr;
    logic       ex_redirect;
    logic       md_done;
    logic [4:0] md_rd_addr;

    logic        stall_pc;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        bubble_id_ex;
    logic        md_issue;
    logic        md_busy;
    logic [31:0] pending;

    // Pipeline side: drives decode/execute state, receives the controls.
    modport master (
        output id_valid, id_rs1_re, id_rs2_re, id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_rd_we, id_opcode, id_funct7,
        output ex_valid, ex_is_load, ex_rd_we, ex_rd_addr, ex_redirect,
        output md_done, md_rd_addr,
        input  stall_pc, stall_if_id, flush_if_id, bubble_id_ex, md_issue, md_busy, pending
    );

    modport slave (
        input  id_valid, id_rs1_re, id_rs2_re, id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  id_rd_we, id_opcode, id_funct7,
        input  ex_valid, ex_is_load, ex_rd_we, ex_rd_addr, ex_redirect,
        input  md_done, md_rd_addr,
        output stall_pc, stall_if_id, flush_if_id, bubble_id_ex, md_issue, md_busy, pending
    );

endinterface

// File: rtl/md_scoreboard.sv
// Pending-destination scoreboard and busy flag for the single-slot multiply/divide unit.
module md_scoreboard
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_issue,
    input  logic        rd_we,
    input  logic [4:0]  rd_addr,
    input  logic        md_done,
    input  logic [4:0]  done_addr,
    output logic [31:0] pending,
    output logic [31:0] pending_fwd,
    output logic        md_busy
);

    logic [31:0] pending_q, pending_d;
    logic [31:0] done_mask, set_mask;
    logic        busy_q, busy_d;

    always_comb begin
        done_mask = '0;
        set_mask  = '0;
        if (md_done) begin
            done_mask = 32'd1 << done_addr;
        end
        if (md_issue && rd_we && (rd_addr != 5'd0)) begin
            set_mask = 32'd1 << rd_addr;
        end
        // Set is applied after clear so a same-bit issue wins.
        pending_d = (pending_q & ~done_mask) | set_mask;
        busy_d    = busy_q;
        if (md_issue) begin
            busy_d = 1'b1;
        end else if (md_done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    assign pending     = pending_q;
    // The completing result is forwarded at writeback, so its bit no longer blocks.
    assign pending_fwd = pending_q & ~done_mask;
    assign md_busy     = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side hazard detection, stall/flush/bubble priority and MD issue for the 5-stage core.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MD_MAX_OUTSTANDING = 1,
    parameter int unsigned STALL_CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_ctrl_if.slave           bus,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output hz_state_t              state
);

    if (MD_MAX_OUTSTANDING != 1) begin : g_md_max_check
        $error("hazard_ctrl supports exactly one outstanding MD operation");
    end

    hz_state_t               state_q, state_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [31:0]             pending, pending_fwd;
    logic                    md_busy;
    logic                    is_md, lu, sb, st, hazard;
    logic                    rs1_live, rs2_live, rd_live;
    logic                    stall_pc, md_issue;

    md_scoreboard u_md_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_issue    (md_issue),
        .rd_we       (bus.id_rd_we),
        .rd_addr     (bus.id_rd_addr),
        .md_done     (bus.md_done),
        .done_addr   (bus.md_rd_addr),
        .pending     (pending),
        .pending_fwd (pending_fwd),
        .md_busy     (md_busy)
    );

    always_comb begin
        is_md    = is_md_op(bus.id_opcode, bus.id_funct7);
        rs1_live = bus.id_rs1_re && (bus.id_rs1_addr != 5'd0);
        rs2_live = bus.id_rs2_re && (bus.id_rs2_addr != 5'd0);
        rd_live  = bus.id_rd_we && (bus.id_rd_addr != 5'd0);

        lu = bus.ex_valid && bus.ex_is_load && bus.ex_rd_we && (bus.ex_rd_addr != 5'd0) &&
             ((rs1_live && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
              (rs2_live && (bus.id_rs2_addr == bus.ex_rd_addr)));
        sb = (rs1_live && pending_fwd[bus.id_rs1_addr]) ||
             (rs2_live && pending_fwd[bus.id_rs2_addr]) ||
             (rd_live && pending_fwd[bus.id_rd_addr]);
        st = is_md && md_busy && !bus.md_done;
        hazard = bus.id_valid && (lu || sb || st);
    end

    always_comb begin
        stall_pc         = 1'b0;
        bus.stall_if_id  = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.bubble_id_ex = 1'b0;
        md_issue         = 1'b0;
        state_d          = state_q;

        if (bus.ex_redirect) begin
            bus.flush_if_id  = 1'b1;
            bus.bubble_id_ex = 1'b1;
        end else if (hazard) begin
            stall_pc         = 1'b1;
            bus.stall_if_id  = 1'b1;
            bus.bubble_id_ex = 1'b1;
        end else begin
            md_issue = bus.id_valid && is_md;
        end

        if (bus.ex_redirect) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.id_valid && lu) begin
                        state_d = LU_STALL;
                    end else if (bus.id_valid && (sb || st)) begin
                        state_d = MD_WAIT;
                    end
                end
                LU_STALL: state_d = RUN;
                MD_WAIT: begin
                    if (!(bus.id_valid && (sb || st))) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_pc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_pc = stall_pc;
    assign bus.md_issue = md_issue;
    assign bus.md_busy  = md_busy;
    assign bus.pending  = pending;
    assign stall_cnt    = stall_cnt_q;
    assign state        = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and issue controller for the five-stage RV64 core (IF/ID/EX/MEM/WB). It sits beside the decode stage and takes the decoded register-use fields and the opcode/funct7. It drives the stall, flush and bubble controls for the IF/ID and ID/EX pipeline registers. It also owns the scoreboard for the shared multi-cycle multiply/divide (MD) unit and arbitrates that unit's single issue slot.

## Interface
- `MD_MAX_OUTSTANDING`, default 1: MD ops in flight; only 1 is supported.
- `STALL_CNT_W`, default 32: width of the stall performance counter.

- Clk  in  1  core clock; all state updates on its rising edge
- RstN  in  1  asynchronous, active-low reset
- IdValid  in  1  ID stage holds a live instruction
- IdRs1ReadEnable / IdRs2ReadEnable  in  1 each  decoded source-use flags
- IdRs1Addr / IdRs2Addr / IdRdAddr  in  5 each  decoded register indices
- IdRdWriteEnable  in  1  decoded destination-write flag
- IdOpCode  in  7  instruction[6:0]
- IdFunct7  in  7  instruction[31:25]
- ExValid  in  1  EX stage holds a live instruction
- ExIsLoad  in  1  EX instruction has opcode 0000011
- ExRdWriteEnable  in  1  EX destination-write flag
- ExRdAddr  in  5  EX destination register
- ExRedirect  in  1  EX resolved a taken branch, JAL or JALR
- MdDone  in  1  MD unit result valid this cycle (one-cycle pulse)
- MdRdAddr  in  5  destination of the completing MD op
- StallPc  out  1  hold the PC
- StallIfId  out  1  hold the IF/ID register
- FlushIfId  out  1  clear the IF/ID register to invalid
- BubbleIdEx  out  1  load a NOP/invalid into ID/EX
- MdIssue  out  1  ID instruction is dispatched to the MD unit this cycle
- MdBusy  out  1  an MD op is outstanding
- Pending  out  32  scoreboard; bit i means x_i awaits an MD result
- StallCnt  out  STALL_CNT_W  cycles in which StallPc was asserted

## Operation
- IsMd: IdOpCode is 0110011 or 0111011 and IdFunct7 is 0000001.
- Register x0 is never a hazard source and is never marked pending.
- Load-use hazard (LU):
  - Condition: ExValid, ExIsLoad and ExRdWriteEnable, with ExRdAddr≠0.
  - ExRdAddr matches an enabled ID source.
- Scoreboard hazard (SB):
  - An enabled ID source, or the ID destination (WAW), has its Pending bit set.
  - The hazard is ignored when MdDone is high with the same MdRdAddr this cycle, because writeback forwards that result.
- Structural hazard (ST): IsMd, MdBusy high and MdDone low.
- Hazard = IdValid and (LU or SB or ST).
- Priority is ExRedirect first, then Hazard, then normal flow.
  - ExRedirect: FlushIfId=1, BubbleIdEx=1, StallPc=0, StallIfId=0. The ID instruction is killed and no MdIssue occurs.
  - Hazard: StallPc=1, StallIfId=1, BubbleIdEx=1, FlushIfId=0.
  - Normal flow: all controls are 0. MdIssue = IdValid and IsMd.
- Scoreboard update at each edge:
  - MdDone clears Pending[MdRdAddr].
  - MdIssue then sets Pending[IdRdAddr] when IdRdWriteEnable is high and IdRdAddr≠0. If both touch the same bit, the set wins.
- MdBusy: set by MdIssue, cleared by MdDone. Issue and done in the same cycle leaves it set.
- FSM (state register `state`, reported for debug):
  - RUN goes to LU_STALL on LU, or to MD_WAIT on SB or ST.
  - LU_STALL returns to RUN on the next cycle. The load has moved to MEM, so LU cannot persist.
  - MD_WAIT returns to RUN in the first cycle in which SB and ST are both false.
  - ExRedirect forces RUN from any state.
- StallCnt increments each cycle in which StallPc=1 and saturates at all-ones.

## Timing
- All control outputs are combinational from the ID/EX inputs plus registered Pending/MdBusy/state. There is no added latency.
- A load-use stall lasts exactly 1 cycle. An MD-dependent stall lasts until the MdDone cycle inclusive; the consumer proceeds in that cycle.
- Pending and MdBusy become visible the cycle after MdIssue.
- Reset (asynchronous, any time, including mid-stall or with an MD op outstanding):
  - Pending=0, MdBusy=0, StallCnt=0, state=RUN.
  - With the inputs idle, all control outputs are 0.
  - An MdDone arriving after reset is ignored, because clearing an already-clear bit is harmless.

## Structure
- The shared package `core_pkg` holds:
  - opcode constants OP_LOAD=0000011, OP_OP=0110011, OP_OP32=0111011, OP_BRANCH=1100011, OP_JAL=1101111 and OP_JALR=1100111;
  - FUNCT7_MULDIV=0000001;
  - the FSM enum `hz_state_t` {RUN, LU_STALL, MD_WAIT}.
- One sub-module, `md_scoreboard`, holds Pending and MdBusy with their set/clear/bypass logic. `hazard_ctrl` contains the hazard detection, priority, FSM and counter.

## Test plan
- Load-use: EX holds `ld x5`; ID holds `add x6,x5,x7` → one cycle of StallPc=StallIfId=BubbleIdEx=1, then release; StallCnt=1.
- Load to x0: EX holds `ld x0` and ID reads x0 → no stall.
- MD dependency:
  - `mul x10,x1,x2` issues → Pending[10]=1 next cycle.
  - `add x11,x10,x3` then stalls until MdDone with MdRdAddr=10, and proceeds in the MdDone cycle.
  - Pending[10]=0 the cycle after.
- Structural and back-to-back:
  - A second `div` while MdBusy stalls.
  - With MdDone and the new issue in the same cycle, MdBusy stays 1 and the Pending bits are updated correctly.
- Redirect: ExRedirect together with a load-use condition → FlushIfId=1, BubbleIdEx=1, StallPc=0, no MdIssue, state=RUN.
- Reset: assert RstN low mid-MD_WAIT → Pending=0, MdBusy=0, StallCnt=0, all outputs 0.
